uart_prog_loader: RTL and testbench

Serial boot loader that is the writer side of the core's instruction memory. It receives a framed program image over UART and writes 32-bit words into the imem write port. It holds the core in reset until a complete, checksum-valid image has been written. It sits between the board UART pin and the riscv_core imem/reset inputs, so test programs load without resynthesis.

---
 rtl/loader_pkg.sv | 25 ++
 rtl/uart_rx.sv | 87 ++++++++
 rtl/uart_prog_loader.sv | 153 +++++++++++++++
 tb/tb_uart_prog_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and frame constants for the UART program loader
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      DONE,
      ERR
   } loader_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int         LEN_BYTES         = 2;
   localparam int         WORD_BYTES        = 4;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: 2-flop synchronizer, bit timer, mid-bit sampling
module uart_rx
   import loader_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

   rx_state_t        rstate, rstate_n;
   logic             rx_s1, rx_s2, rx_d;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shreg, shreg_n;
   logic             byte_valid_n, frame_err_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_d       <= 1'b1;
         rstate     <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_s1      <= rx;
         rx_s2      <= rx_s1;
         rx_d       <= rx_s2;
         rstate     <= rstate_n;
         cnt        <= cnt_n;
         bit_idx    <= bit_idx_n;
         shreg      <= shreg_n;
         byte_valid <= byte_valid_n;
         frame_err  <= frame_err_n;
      end
   end

   always_comb begin
      rstate_n     = rstate;
      cnt_n        = cnt + 1'b1;
      bit_idx_n    = bit_idx;
      shreg_n      = shreg;
      byte_valid_n = 1'b0;
      frame_err_n  = 1'b0;
      case (rstate)
         RX_IDLE: begin
            cnt_n = '0;
            if (rx_d && !rx_s2) rstate_n = RX_START;
         end
         // a start bit that is high again at half a bit time was only a glitch
         RX_START: if (cnt == HALF_CNT) begin
            cnt_n     = '0;
            bit_idx_n = '0;
            rstate_n  = rx_s2 ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (cnt == FULL_CNT) begin
            cnt_n     = '0;
            shreg_n   = {rx_s2, shreg[7:1]};
            bit_idx_n = bit_idx + 1'b1;
            if (bit_idx == 3'd7) rstate_n = RX_STOP;
         end
         RX_STOP: if (cnt == FULL_CNT) begin
            cnt_n        = '0;
            byte_valid_n = rx_s2;
            frame_err_n  = !rx_s2;
            rstate_n     = RX_IDLE;
         end
         default: rstate_n = RX_IDLE;
      endcase
   end

   assign byte_data = shreg;

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - framed UART image loader driving imem writes and core hold; option LOADER_TIMEOUT_EN
module uart_prog_loader
   import loader_pkg::*;
#(
   parameter int         CLK_FREQ       = 100_000_000,
   parameter int         BAUD           = 115200,
   parameter int         ADDR_W         = 10,
`ifdef LOADER_TIMEOUT_EN
   parameter int         TIMEOUT_CYCLES = 1_000_000,
`endif
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              load_done,
   output logic              load_err
);
   localparam int LEN_W = 8 * LEN_BYTES;
   localparam int IDX_W = $clog2(WORD_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_BYTES - 1);
   localparam logic [LEN_W:0]   MAX_WORDS = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

   logic        byte_valid, frame_err;
   logic [7:0]  byte_data;

   loader_state_t     state, state_n;
   logic [7:0]        len_lo, len_lo_n;
   logic [LEN_W-1:0]  len, len_n, wcnt, wcnt_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [31:0]       word, word_n, wdata_n;
   logic [7:0]        sum, sum_n;
   logic              we_n;
   logic [ADDR_W-1:0] addr_n;
   logic              active, tmo_hit;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (uart_rx),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .frame_err (frame_err)
   );

   assign active    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
   assign core_hold = (state != DONE);
   assign load_done = (state == DONE);
   assign load_err  = (state == ERR);

`ifdef LOADER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;

   // counts cycles since the last byte, so it equals TIMEOUT_CYCLES-1 one cycle before expiry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            tmo_cnt <= '0;
      else if (byte_valid) tmo_cnt <= TMO_W'(1);
      else if (active)     tmo_cnt <= tmo_cnt + 1'b1;
      else                 tmo_cnt <= '0;
   end

   assign tmo_hit = active && !byte_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         len_lo     <= '0;
         len        <= '0;
         wcnt       <= '0;
         idx        <= '0;
         word       <= '0;
         sum        <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         state      <= state_n;
         len_lo     <= len_lo_n;
         len        <= len_n;
         wcnt       <= wcnt_n;
         idx        <= idx_n;
         word       <= word_n;
         sum        <= sum_n;
         imem_we    <= we_n;
         imem_addr  <= addr_n;
         imem_wdata <= wdata_n;
      end
   end

   always_comb begin
      state_n  = state;
      len_lo_n = len_lo;
      len_n    = len;
      wcnt_n   = wcnt;
      idx_n    = idx;
      word_n   = word;
      sum_n    = sum;
      we_n     = 1'b0;
      addr_n   = imem_addr;
      wdata_n  = imem_wdata;
      case (state)
         IDLE: if (byte_valid && byte_data == SYNC_BYTE) state_n = LEN_LO;
         LEN_LO: if (byte_valid) begin
            len_lo_n = byte_data;
            state_n  = LEN_HI;
         end
         LEN_HI: if (byte_valid) begin
            len_n  = {byte_data, len_lo};
            addr_n = '0;
            wcnt_n = '0;
            idx_n  = '0;
            sum_n  = '0;
            if ({1'b0, len_n} > MAX_WORDS) state_n = ERR;
            else if (len_n == '0)          state_n = CSUM;
            else                           state_n = DATA;
         end
         DATA: begin
            if (byte_valid) begin
               word_n[{idx, 3'b000} +: 8] = byte_data;
               sum_n = sum + byte_data;
               idx_n = idx + 1'b1;
               if (idx == LAST_IDX) begin
                  we_n    = 1'b1;
                  wdata_n = word_n;
               end
            end
            // the address moves on only once the strobe for the current word has gone out
            if (imem_we) begin
               wcnt_n = wcnt + 1'b1;
               if (wcnt_n == len) begin
                  addr_n  = '0;
                  state_n = CSUM;
               end else begin
                  addr_n = imem_addr + 1'b1;
               end
            end
         end
         CSUM: if (byte_valid) state_n = (byte_data == sum) ? DONE : ERR;
         DONE, ERR: if (byte_valid && byte_data == SYNC_BYTE) state_n = LEN_LO;
         default: state_n = IDLE;
      endcase
      if (active && (frame_err || tmo_hit)) state_n = ERR;
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader (table vectors, corner sequences, random frames)
module tb_uart_prog_loader;
   localparam int CPB = 10;
   localparam int AW  = 2;
   localparam int NV  = 7;

   logic          clk     = 1'b0;
   logic          rst     = 1'b0;
   logic          uart_rx = 1'b1;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_hold, load_done, load_err;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int last_bv = 0;

   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];
   logic [31:0]   exp_w[$];
   logic          exp_done, exp_err;

   typedef struct {
      int          nb;
      logic [7:0]  b [20];
      int          bad;
      int          nwr;
      logic        done;
      logic [31:0] w0;
      logic [31:0] w1;
   } vec_t;
   vec_t tv[NV];

   uart_prog_loader #(
      .CLK_FREQ(1_000_000),
      .BAUD    (100_000),
      .ADDR_W  (AW),
`ifdef LOADER_TIMEOUT_EN
      .TIMEOUT_CYCLES(500),
`endif
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .uart_rx   (uart_rx),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .core_hold (core_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
      end
      if (dut.byte_valid) last_bv = cyc;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: time budget exhausted");
      $fatal(1, "bench watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] qget(input int i);
      return (i < wr_data.size()) ? wr_data[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic addr_seq_ok();
      logic ok = 1'b1;
      foreach (wr_addr[i]) if (wr_addr[i] != AW'(i)) ok = 1'b0;
      return ok;
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic do_reset();
      rst     = 1'b0;
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic set_vec(input int k, input int nb, input logic [159:0] bytes, input int bad,
                          input int nwr, input logic done, input logic [31:0] w0, input logic [31:0] w1);
      tv[k].nb = nb;
      for (int i = 0; i < nb; i++) tv[k].b[i] = bytes[8*(nb-1-i) +: 8];
      tv[k].bad  = bad;
      tv[k].nwr  = nwr;
      tv[k].done = done;
      tv[k].w0   = w0;
      tv[k].w1   = w1;
   endtask

   // reference: parse the frame by its field layout and derive writes and verdict
   task automatic model(input logic [7:0] q[$]);
      int         i = 0;
      int         n;
      logic [7:0] s = 8'h00;
      logic [31:0] w;
      exp_w.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      while (i < q.size() && q[i] != 8'hA5) i++;
      n = q[i+1] + 256 * q[i+2];
      if (n > (1 << AW)) begin
         exp_err = 1'b1;
         return;
      end
      for (int k = 0; k < n; k++) begin
         w = 32'h0;
         for (int j = 0; j < 4; j++) begin
            w = w + (32'(q[i+3+4*k+j]) << (8*j));
            s = s + q[i+3+4*k+j];
         end
         exp_w.push_back(w);
      end
      if (q[i+3+4*n] == s) exp_done = 1'b1;
      else                 exp_err  = 1'b1;
   endtask

   initial begin
      logic [7:0] fq[$];
      int         n, t_err;
      logic [7:0] s, jb;

      set_vec(0, 12, 96'hA5_02_00_13_00_00_00_93_00_10_00_B6, -1, 2, 1'b1, 32'h0000_0013, 32'h0010_0093);
      set_vec(1, 12, 96'hA5_02_00_13_00_00_00_93_00_10_00_B7, -1, 2, 1'b0, 32'h0000_0013, 32'h0010_0093);
      set_vec(2, 3,  24'hA5_05_00, -1, 0, 1'b0, 32'h0, 32'h0);
      set_vec(3, 4,  32'hA5_00_00_00, -1, 0, 1'b1, 32'h0, 32'h0);
      set_vec(4, 11, 88'h00_FF_3C_A5_01_00_78_56_34_12_14, -1, 1, 1'b1, 32'h1234_5678, 32'h0);
      set_vec(5, 8,  64'hA5_02_00_13_00_00_00_93, 7, 1, 1'b0, 32'h0000_0013, 32'h0);
      set_vec(6, 20, 160'hA5_04_00_01_00_00_00_02_00_00_00_03_00_00_00_04_00_00_00_0A, -1, 4, 1'b1,
              32'h0000_0001, 32'h0000_0002);

      repeat (2) @(negedge clk);
      check("rst_we",    imem_we,    0);
      check("rst_addr",  imem_addr,  0);
      check("rst_wdata", imem_wdata, 0);
      check("rst_hold",  core_hold,  1);
      check("rst_done",  load_done,  0);
      check("rst_err",   load_err,   0);

      for (int k = 0; k < NV; k++) begin
         do_reset();
         for (int i = 0; i < tv[k].nb; i++) send_byte(tv[k].b[i], i != tv[k].bad);
         repeat (5) @(negedge clk);
         check($sformatf("v%0d_nwr", k),  wr_data.size(), tv[k].nwr);
         check($sformatf("v%0d_done", k), load_done, tv[k].done);
         check($sformatf("v%0d_err", k),  load_err,  !tv[k].done);
         check($sformatf("v%0d_hold", k), core_hold, !tv[k].done);
         check($sformatf("v%0d_addr_seq", k), addr_seq_ok(), 1);
         if (tv[k].nwr > 0) check($sformatf("v%0d_w0", k), qget(0), tv[k].w0);
         if (tv[k].nwr > 1) check($sformatf("v%0d_w1", k), qget(1), tv[k].w1);
      end

      // short low glitch between sync and length must not be taken as a byte
      do_reset();
      send_byte(8'hA5, 1'b1);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (30) @(negedge clk);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      repeat (5) @(negedge clk);
      check("glitch_done", load_done, 1);
      check("glitch_err",  load_err,  0);

      // reload from DONE: hold rises the cycle after the sync byte arrives
      do_reset();
      for (int i = 0; i < tv[0].nb; i++) send_byte(tv[0].b[i], 1'b1);
      repeat (5) @(negedge clk);
      check("reload_pre_done", load_done, 1);
      fork
         send_byte(8'hA5, 1'b1);
         begin
            int seen = 0;
            for (int i = 0; i < 200 && seen == 0; i++) begin
               @(negedge clk);
               if (dut.byte_valid) seen = 1;
            end
            check("reload_bv_seen", seen, 1);
            check("reload_hold_same", core_hold, 0);
            @(negedge clk);
            check("reload_hold_next", core_hold, 1);
            check("reload_done_clr",  load_done, 0);
         end
      join

      // asynchronous reset in the middle of the second word
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h13 : 8'h00, 1'b1);
      repeat (3) @(negedge clk);
      check("pre_rst_addr", imem_addr, 1);
      fork
         send_byte(8'h93, 1'b1);
         begin
            repeat (30) @(negedge clk);
            #2 rst = 1'b0;
            #1;
            check("mid_rst_we",    imem_we,    0);
            check("mid_rst_addr",  imem_addr,  0);
            check("mid_rst_wdata", imem_wdata, 0);
            check("mid_rst_hold",  core_hold,  1);
            check("mid_rst_done",  load_done,  0);
            check("mid_rst_err",   load_err,   0);
         end
      join
      repeat (3) @(negedge clk);
      check("mid_rst_nwr", wr_data.size(), 1);
      rst = 1'b1;
      @(negedge clk);

      // stall after three data bytes
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h13, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
`ifdef LOADER_TIMEOUT_EN
      t_err = -1;
      for (int i = 0; i < 1000 && t_err < 0; i++) begin
         @(negedge clk);
         if (load_err) t_err = cyc;
      end
      check("tmo_latency", t_err - last_bv, 500);
      check("tmo_hold", core_hold, 1);
`else
      t_err = 0;
      repeat (600) @(negedge clk);
      check("stall_err",  load_err,  0);
      check("stall_done", load_done, 0);
      check("stall_data", dut.state == loader_pkg::DATA, 1);
`endif

      // random frames back to back, exercising reload from DONE and ERR
      do_reset();
      for (int f = 0; f < 10; f++) begin
         fq.delete();
         for (int j = $urandom_range(0, 2); j > 0; j--) begin
            jb = 8'($urandom_range(0, 255));
            if (jb == 8'hA5) jb = 8'h5A;
            fq.push_back(jb);
         end
         n = $urandom_range(0, 5);
         fq.push_back(8'hA5);
         fq.push_back(8'(n));
         fq.push_back(8'h00);
         if (n <= (1 << AW)) begin
            s = 8'h00;
            for (int j = 0; j < 4 * n; j++) begin
               jb = 8'($urandom_range(0, 255));
               s  = s + jb;
               fq.push_back(jb);
            end
            if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
            fq.push_back(s);
         end
         model(fq);
         wr_addr.delete();
         wr_data.delete();
         foreach (fq[j]) send_byte(fq[j], 1'b1);
         repeat (5) @(negedge clk);
         check($sformatf("r%0d_nwr", f),  wr_data.size(), exp_w.size());
         check($sformatf("r%0d_done", f), load_done, exp_done);
         check($sformatf("r%0d_err", f),  load_err,  exp_err);
         check($sformatf("r%0d_hold", f), core_hold, !exp_done);
         check($sformatf("r%0d_addr_seq", f), addr_seq_ok(), 1);
         foreach (exp_w[j]) check($sformatf("r%0d_w%0d", f, j), qget(j), exp_w[j]);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
